// File: rtl/sfu_pkg.sv
// sfu_pkg: shared lane geometry and FSM state type for the SFU AXIS transmitter
package sfu_pkg;
  localparam int SFU_LANE_W = 16;
  localparam int SFU_NUM_CH = 32;
  typedef enum logic {IDLE, SEND} sfu_state_e;
endpackage

// File: rtl/sfu_axis_fifo.sv
// sfu_axis_fifo: synchronous FIFO with head read from registered storage and MSB-compare full/empty
module sfu_axis_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic [W-1:0] mem_q [DEPTH];
  assign full_o  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign empty_o = wr_q == rd_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];
  // pointer advance; each pointer wraps through the extra MSB
  always_comb begin
    wr_d = (push_i && !full_o) ? wr_q + (AW+1)'(1) : wr_q;
    rd_d = (pop_i && !empty_o) ? rd_q + (AW+1)'(1) : rd_q;
  end
  // pointer registers; clearing them is enough to discard buffered beats
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end
  // storage write; contents are don't-care until a pointer makes them visible
  always_ff @(posedge clk) begin
    if (push_i && !full_o) mem_q[wr_q[AW-1:0]] <= din_i;
  end
endmodule

// File: rtl/sfu_axis_tx.sv
// sfu_axis_tx: buffers SFU result beats of one step and streams them out on AXIS with tlast
module sfu_axis_tx
  import sfu_pkg::*;
#(
  parameter int NUM_CH     = SFU_NUM_CH,
  parameter int DATA_W     = SFU_LANE_W,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               params_step_num,
  input  logic                     start,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic [NUM_CH*DATA_W-1:0] s_data,
  output logic                     m_sfu_axis_tvalid,
  input  logic                     m_sfu_axis_tready,
  output logic [NUM_CH*DATA_W-1:0] m_sfu_axis_tdata,
  output logic                     m_sfu_axis_tlast,
  output logic                     busy,
  output logic                     step_done,
  output logic                     err_flag
);
  sfu_state_e state_q, state_d;
  logic [7:0] step_num_q, step_num_d, in_cnt_q, in_cnt_d, out_cnt_q, out_cnt_d;
  logic       err_q, err_d, done_q, done_d;
  logic       full, empty, push, pop;
  assign busy              = state_q == SEND;
  assign s_ready           = busy && !full && (in_cnt_q < step_num_q);
  assign push              = s_valid && s_ready;
  assign m_sfu_axis_tvalid = !empty;
  assign pop               = m_sfu_axis_tvalid && m_sfu_axis_tready;
  assign m_sfu_axis_tlast  = m_sfu_axis_tvalid && (out_cnt_q == step_num_q - 8'd1);
  assign step_done         = done_q;
  assign err_flag          = err_q;
  sfu_axis_fifo #(.W(NUM_CH*DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .din_i   (s_data),
    .pop_i   (pop),
    .dout_o  (m_sfu_axis_tdata),
    .full_o  (full),
    .empty_o (empty)
  );
  // step control: open on a valid start, count beats both ways, close on the tlast handshake
  always_comb begin
    state_d    = state_q;
    step_num_d = step_num_q;
    in_cnt_d   = push ? in_cnt_q + 8'd1 : in_cnt_q;
    out_cnt_d  = pop ? out_cnt_q + 8'd1 : out_cnt_q;
    err_d      = err_q || start && (busy || params_step_num == 8'd0);
    done_d     = 1'b0;
    if (state_q == IDLE) begin
      if (start && params_step_num != 8'd0) begin
        state_d    = SEND;
        step_num_d = params_step_num;
        in_cnt_d   = 8'd0;
        out_cnt_d  = 8'd0;
      end
    end else if (pop && m_sfu_axis_tlast) begin
      state_d = IDLE;
      done_d  = 1'b1;
    end
  end
  // control registers; err_q is sticky until reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      step_num_q <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_num_q <= step_num_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      err_q      <= err_d;
      done_q     <= done_d;
    end
  end
endmodule

// File: tb/tb_sfu_axis_tx.sv
// tb_sfu_axis_tx: random-stimulus scoreboard bench for sfu_axis_tx
module tb_sfu_axis_tx;
  localparam int NC = 32, DW = 16, W = NC * DW, DEPTH = 4;
  logic clk = 0, rst = 0, start = 0, s_valid = 0, tready = 0;
  logic [7:0] params_step_num = 0;
  logic [W-1:0] s_data = '0;
  logic s_ready, tvalid, tlast, busy, step_done, err_flag;
  logic [W-1:0] tdata;
  sfu_axis_tx dut (
    .clk(clk), .rst(rst), .params_step_num(params_step_num), .start(start),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_sfu_axis_tvalid(tvalid), .m_sfu_axis_tready(tready),
    .m_sfu_axis_tdata(tdata), .m_sfu_axis_tlast(tlast),
    .busy(busy), .step_done(step_done), .err_flag(err_flag)
  );
  always #5 clk = ~clk;
  int n_cmp = 0, n_err = 0;
  logic [W-1:0] q[$];
  int acc = 0, popped = 0, step_m = 0, done_cnt = 0, seq = 0;
  bit busy_m, err_m, done_m, nxt_done, b0, stall_q, stall_last, acc_flag, ihs, ohs;
  logic [W-1:0] stall_data;
  bit src_en = 0, rdy_rand = 0, rdy_fix = 1, val_rand = 0;
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic miss(input string nm);
    n_cmp++;
    n_err++;
    $display("FAIL %s: event did not occur", nm);
  endtask
  // source and sink driver: new beat only after the previous one was accepted
  initial forever begin
    @(posedge clk);
    #1;
    tready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fix;
    if (!src_en) s_valid = 0;
    else if (!s_valid || acc_flag) begin
      s_valid = val_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      if (s_valid) begin
        for (int i = 0; i < W / 32; i++) s_data[i*32 +: 32] = $urandom;
        s_data[15:0] = seq[15:0];
        seq++;
      end
    end
  end
  // reference model and monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (!rst) begin
      chk("rst_tvalid", tvalid, 0);
      chk("rst_s_ready", s_ready, 0);
      chk("rst_tlast", tlast, 0);
      chk("rst_busy", busy, 0);
      chk("rst_step_done", step_done, 0);
      chk("rst_err_flag", err_flag, 0);
      q.delete();
      acc = 0; popped = 0; step_m = 0;
      busy_m = 0; err_m = 0; done_m = 0; stall_q = 0; acc_flag = 0;
    end else begin
      chk("tvalid", tvalid, q.size() != 0);
      chk("s_ready", s_ready, busy_m && q.size() < DEPTH && acc < step_m);
      chk("busy", busy, busy_m);
      chk("err_flag", err_flag, err_m);
      chk("step_done", step_done, done_m);
      chk("tlast", tlast, q.size() != 0 && popped == step_m - 1);
      if (stall_q) begin
        chk("hold_tdata", tdata, stall_data);
        chk("hold_tlast", tlast, stall_last);
      end
      ihs = s_valid && s_ready;
      ohs = tvalid && tready;
      b0 = busy_m;
      nxt_done = 0;
      acc_flag = ihs;
      if (ohs) begin
        if (q.size() == 0) miss("beat_expected");
        else begin
          chk("tdata", tdata, q.pop_front());
          popped++;
          if (popped == step_m) begin
            busy_m = 0;
            nxt_done = 1;
          end
        end
      end
      if (ihs) begin
        q.push_back(s_data);
        acc++;
      end
      stall_q = tvalid && !tready;
      stall_data = tdata;
      stall_last = tlast;
      if (start) begin
        if (b0 || params_step_num == 0) err_m = 1;
        else begin
          busy_m = 1;
          step_m = params_step_num;
          acc = 0;
          popped = 0;
        end
      end
      done_m = nxt_done;
      if (nxt_done) done_cnt++;
    end
  end
  task automatic do_start(input int n);
    @(posedge clk);
    #1;
    params_step_num = 8'(n);
    start = 1;
    @(posedge clk);
    #1;
    start = 0;
  endtask
  task automatic wait_done(input string nm, input int budget);
    int c0 = done_cnt;
    for (int i = 0; i < budget; i++) begin
      @(posedge clk);
      if (done_cnt != c0) return;
    end
    miss(nm);
  endtask
  initial begin
    repeat (3) @(negedge clk);
    #2;
    rst = 1;
    src_en = 1;
    do_start(4);
    wait_done("step4_done", 50);
    rdy_fix = 0;
    do_start(8);
    repeat (10) @(posedge clk);
    #2;
    chk("stall_accepted", acc, DEPTH);
    chk("stall_s_ready", s_ready, 0);
    rdy_fix = 1;
    wait_done("step8_done", 100);
    do_start(3);
    wait_done("step3_done", 50);
    #2;
    chk("step3_accepted", acc, 3);
    do_start(0);
    repeat (3) @(posedge clk);
    rdy_fix = 0;
    do_start(4);
    repeat (2) @(posedge clk);
    do_start(5);
    repeat (3) @(posedge clk);
    rdy_fix = 1;
    wait_done("err_step_done", 50);
    #2;
    chk("err_sticky", err_flag, 1);
    rdy_fix = 0;
    do_start(6);
    for (int i = 0; i < 20 && acc != 2; i++) begin
      @(posedge clk);
      #2;
    end
    if (acc != 2) miss("two_buffered");
    #1;
    rst = 0;
    #1;
    chk("arst_tvalid", tvalid, 0);
    chk("arst_s_ready", s_ready, 0);
    chk("arst_tlast", tlast, 0);
    chk("arst_busy", busy, 0);
    chk("arst_err_flag", err_flag, 0);
    @(negedge clk);
    @(posedge clk);
    #3;
    rst = 1;
    rdy_fix = 1;
    do_start(2);
    wait_done("post_rst_done", 50);
    rdy_rand = 1;
    val_rand = 1;
    do_start(255);
    wait_done("step255_done", 3000);
    #2;
    chk("step255_popped", popped, 255);
    rdy_rand = 0;
    val_rand = 0;
    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/sfu_axis_tx.md
SFU_AXIS_TX -- requirements
Module: sfu_axis_tx

Interface
REQ-001 SHALL have parameter NUM_CH, default 32: number of 16-bit lanes per beat.
REQ-002 SHALL have parameter DATA_W, default 16: lane width in bits.
REQ-003 SHALL have parameter FIFO_DEPTH, default 4: output buffer entries; power of two, at least 2.
REQ-004 SHALL have one clock and an asynchronous active-low reset.
REQ-005 clk  in  1  rising-edge clock.
REQ-006 rst  in  1  reset; asynchronous, active-low.
REQ-007 params_step_num  in  8  beats per step; sampled on start.
REQ-008 start  in  1  single-cycle pulse that opens a step.
REQ-009 s_valid  in  1  SFU result beat valid.
REQ-010 s_ready  out  1  block accepts a beat.
REQ-011 s_data  in  NUM_CH*DATA_W  SFU result lanes.
REQ-012 m_sfu_axis_tvalid  out  1  AXIS valid.
REQ-013 m_sfu_axis_tready  in  1  AXIS ready.
REQ-014 m_sfu_axis_tdata  out  NUM_CH*DATA_W  AXIS data; lane 0 sits in the LSBs.
REQ-015 m_sfu_axis_tlast  out  1  marks the final beat of a step.
REQ-016 busy  out  1  a step is in progress.
REQ-017 step_done  out  1  one-cycle pulse after the last beat handshakes.
REQ-018 err_flag  out  1  sticky protocol-error flag.

Function
REQ-019 SHALL implement FSM states IDLE and SEND.
REQ-020 IDLE to SEND: start=1 and params_step_num!=0; the block latches step_num and clears in_cnt and out_cnt.
REQ-021 start with params_step_num==0 SHALL set err_flag and leave the FSM in IDLE.
REQ-022 start while in SEND SHALL be ignored and SHALL set err_flag.
REQ-023 s_ready = (state==SEND) && !fifo_full && (in_cnt < step_num); s_ready SHALL be 0 in IDLE, and s_valid in IDLE SHALL NOT set err_flag.
REQ-024 Input handshake (s_valid && s_ready): push s_data into the FIFO and increment in_cnt.
REQ-025 m_sfu_axis_tvalid = !fifo_empty; tdata = FIFO head.
REQ-026 tdata and tlast SHALL hold stable while tvalid=1 and tready=0.
REQ-027 Latency: a beat accepted in cycle N SHALL first appear on tvalid in cycle N+1; no combinational path from s_valid/s_data to the m_ side.
REQ-028 Output handshake (tvalid && tready): pop the FIFO and increment out_cnt.
REQ-029 tlast SHALL be 1 exactly when tvalid=1 and out_cnt==step_num-1.
REQ-030 On the tlast handshake: step_done=1 on the next cycle and the FSM returns to IDLE.
REQ-031 Simultaneous push and pop SHALL leave the FIFO occupancy unchanged and SHALL be legal at any occupancy below full.
REQ-032 At full, s_ready SHALL be 0 even if a pop occurs in the same cycle.
REQ-033 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits and wrap naturally; full and empty are decided by pointer MSB compare.
REQ-034 in_cnt and out_cnt SHALL be 8 bits and never exceed step_num.
REQ-035 busy = (state==SEND).
REQ-036 err_flag SHALL clear only on reset.

Reset
REQ-037 rst=0 SHALL asynchronously force: FSM=IDLE, FIFO empty, counters=0, step_num=0, s_ready=0, tvalid=0, tlast=0, busy=0, step_done=0, err_flag=0.
REQ-038 Reset during SEND SHALL discard buffered beats with no tvalid glitch after release.
REQ-039 FIFO storage SHALL NOT need reset.

Structure
REQ-040 A shared package sfu_pkg SHALL hold the FSM state enum, SFU_LANE_W=16 and SFU_NUM_CH=32.
REQ-041 The FIFO SHALL be a sub-module sfu_axis_fifo (sync, registered head, full/empty outputs).

Verification
REQ-042 step_num=4, tready=1, four back-to-back beats -> 4 beats out at cycles N+1..N+4, tlast on beat 4, step_done one cycle later, busy=0 afterwards.
REQ-043 step_num=8, tready=0 for 10 cycles -> exactly FIFO_DEPTH=4 beats accepted, s_ready=0, tdata stable; after tready=1 all 8 beats delivered in order.
REQ-044 step_num=3 with 5 input beats offered -> only 3 accepted (s_ready=0 after in_cnt=3), tlast on beat 3.
REQ-045 start with step_num=0, and start during SEND -> err_flag=1 and stays 1; FSM unaffected.
REQ-046 rst asserted with 2 beats buffered mid-step -> all outputs 0 immediately; a new step_num=2 step then completes normally.
REQ-047 Random tready, step_num=255 -> ramp data received in order with no loss or duplicate, single tlast on beat 255.
